// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the architectural PC, fetches instruction words
// over a variable-latency req/ready handshake and presents them to IDU_top.
// Optional build macro IFU_TIMEOUT_EN enables the fetch watchdog; without it
// REQ waits indefinitely and fetch_timeout is tied low.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef IFU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        soc_clk,
  input  logic        IFU_reset_n,
  input  logic [1:0]  stage_counter,
  input  logic [1:0]  next_pc_sel,
  input  logic [31:0] pc_increment,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_stall,
  output logic        misaligned_fetch,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] next_pc_c;
  logic        next_aligned_c;
  logic        pc_upd_c;
  logic        handshake_c;
  logic        expire_c;

  // Candidate next PC; CU asserts stage 3 only once the instruction is latched
  always_comb begin
    next_pc_c = pc;
    case (next_pc_sel)
      2'b00:   next_pc_c = pc + 32'd4;
      2'b01:   next_pc_c = pc + pc_increment;
      2'b10:   next_pc_c = jump_target & 32'hFFFF_FFFE;
      default: next_pc_c = pc;
    endcase
    next_aligned_c = (next_pc_c[1:0] == 2'b00);
    pc_upd_c       = (state != ST_REQ) && (stage_counter == 2'd3);
    handshake_c    = (state == ST_REQ) && imem_ready;
  end

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // A handshake on the expiry cycle wins, hence the !imem_ready term
  assign expire_c = (state == ST_REQ) && !imem_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter; zero whenever not accumulating, so entry to REQ sees 0
  always_ff @(posedge soc_clk) begin
    if (!IFU_reset_n) begin
      wait_cnt <= '0;
    end else if ((state == ST_REQ) && !imem_ready && !expire_c) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag, cleared by the next successful handshake
  always_ff @(posedge soc_clk) begin
    if (!IFU_reset_n) begin
      fetch_timeout <= 1'b0;
    end else if (handshake_c) begin
      fetch_timeout <= 1'b0;
    end else if (expire_c) begin
      fetch_timeout <= 1'b1;
    end
  end
`else
  assign expire_c      = 1'b0;
  assign fetch_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge soc_clk) begin
    if (!IFU_reset_n) begin
      state <= ST_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_REQ: begin
        if (handshake_c || expire_c) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD, ST_FAULT: begin
        if (pc_upd_c) begin
          state_next = next_aligned_c ? ST_REQ : ST_FAULT;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  // Outputs decoded from registered state and the PC register only
  always_comb begin
    imem_req    = (state == ST_REQ);
    fetch_stall = (state == ST_REQ);
    imem_addr   = pc;
  end

  // PC, instruction and misaligned-fetch registers
  always_ff @(posedge soc_clk) begin
    if (!IFU_reset_n) begin
      pc               <= RESET_PC;
      instruction      <= NOP_INSTR;
      misaligned_fetch <= 1'b0;
    end else begin
      if (handshake_c) begin
        instruction <= imem_rdata;
      end else if (expire_c) begin
        instruction <= NOP_INSTR;
      end
      if (pc_upd_c) begin
        pc <= next_pc_c;
        if (next_aligned_c) begin
          misaligned_fetch <= 1'b0;
        end else begin
          misaligned_fetch <= 1'b1;
          instruction      <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized PC-sequencing run against a plain-arithmetic reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        soc_clk;
  logic        IFU_reset_n;
  logic [1:0]  stage_counter;
  logic [1:0]  next_pc_sel;
  logic [31:0] pc_increment;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_stall;
  logic        misaligned_fetch;
  logic        fetch_timeout;

  int chks;
  int errs;

  instruction_fetch_unit dut (
    .soc_clk          (soc_clk),
    .IFU_reset_n      (IFU_reset_n),
    .stage_counter    (stage_counter),
    .next_pc_sel      (next_pc_sel),
    .pc_increment     (pc_increment),
    .jump_target      (jump_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .instruction      (instruction),
    .pc               (pc),
    .fetch_stall      (fetch_stall),
    .misaligned_fetch (misaligned_fetch),
    .fetch_timeout    (fetch_timeout)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  // Absolute time limit so the run can never hang
  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge soc_clk);
    #1;
  endtask

  task automatic pc_update(input logic [1:0] sel, input logic [31:0] inc, input logic [31:0] jt);
    stage_counter = 2'd3;
    next_pc_sel   = sel;
    pc_increment  = inc;
    jump_target   = jt;
    tick();
    stage_counter = 2'd0;
  endtask

  task automatic fetch(input logic [31:0] d, input int waits);
    imem_ready = 1'b0;
    repeat (waits) tick();
    imem_ready = 1'b1;
    imem_rdata = d;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset;
    IFU_reset_n = 1'b0;
    imem_ready  = 1'b1;
    imem_rdata  = 32'h1234_50B7;
    tick();
    chks++; if (pc !== 32'h0) begin errs++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    chks++; if (instruction !== NOP) begin errs++; $display("FAIL reset_instr: got %h exp %h", instruction, NOP); end
    chks++; if (imem_req !== 1'b1 || fetch_stall !== 1'b1) begin errs++; $display("FAIL reset_req: got req=%b stall=%b exp 1 1", imem_req, fetch_stall); end
    chks++; if (misaligned_fetch !== 1'b0 || fetch_timeout !== 1'b0) begin errs++; $display("FAIL reset_flags: got mis=%b to=%b exp 0 0", misaligned_fetch, fetch_timeout); end
    tick();
    IFU_reset_n = 1'b1;
    chks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL first_req: got req=%b addr=%h exp 1 0", imem_req, imem_addr); end
    tick();
    imem_ready = 1'b0;
    chks++; if (instruction !== 32'h1234_50B7) begin errs++; $display("FAIL first_instr: got %h exp %h", instruction, 32'h1234_50B7); end
    chks++; if (fetch_stall !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin errs++; $display("FAIL first_hold: got stall=%b req=%b pc=%h exp 0 0 0", fetch_stall, imem_req, pc); end
  endtask

  task automatic test_sequential;
    logic [31:0] d;
    d = $urandom;
    pc_update(2'b00, 32'h0, 32'h0);
    chks++; if (pc !== 32'h4 || imem_addr !== 32'h4) begin errs++; $display("FAIL seq_pc: got pc=%h addr=%h exp 4 4", pc, imem_addr); end
    chks++; if (fetch_stall !== 1'b1 || imem_req !== 1'b1) begin errs++; $display("FAIL seq_stall_on: got stall=%b req=%b exp 1 1", fetch_stall, imem_req); end
    fetch(d, 0);
    chks++; if (fetch_stall !== 1'b0 || instruction !== d) begin errs++; $display("FAIL seq_stall_off: got stall=%b instr=%h exp 0 %h", fetch_stall, instruction, d); end
  endtask

  task automatic test_branch_jump;
    pc_update(2'b10, 32'h0, 32'h0000_0100);
    fetch($urandom, 0);
    pc_update(2'b01, 32'hFFFF_FFF0, 32'h0);
    chks++; if (pc !== 32'h0000_00F0) begin errs++; $display("FAIL branch_neg: got %h exp %h", pc, 32'hF0); end
    fetch($urandom, 1);
    pc_update(2'b10, 32'h0, 32'h0000_0205);
    chks++; if (pc !== 32'h0000_0204 || imem_addr !== 32'h0000_0204) begin errs++; $display("FAIL jump_clr_bit0: got pc=%h addr=%h exp 204", pc, imem_addr); end
    fetch($urandom, 0);
    pc_update(2'b10, 32'h0, 32'hFFFF_FFFC);
    fetch($urandom, 0);
    pc_update(2'b00, 32'h0, 32'h0);
    chks++; if (pc !== 32'h0 || imem_req !== 1'b1) begin errs++; $display("FAIL pc_wrap: got pc=%h req=%b exp 0 1", pc, imem_req); end
    fetch($urandom, 0);
    pc_update(2'b11, 32'h0, 32'h0);
    chks++; if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL sel_hold_refetch: got pc=%h req=%b addr=%h exp 0 1 0", pc, imem_req, imem_addr); end
    fetch($urandom, 0);
  endtask

  task automatic test_wait_states;
    logic [31:0] prev;
    pc_update(2'b10, 32'h0, 32'h0000_0040);
    fetch(32'hDEAD_0001, 0);
    prev = instruction;
    pc_update(2'b00, 32'h0, 32'h0);
    // stage 3 during REQ is a protocol violation the unit must ignore
    stage_counter = 2'd3;
    next_pc_sel   = 2'b10;
    jump_target   = 32'h0000_0ABC;
    for (int i = 0; i < 4; i++) begin
      chks++; if (imem_req !== 1'b1 || fetch_stall !== 1'b1 || imem_addr !== 32'h44 || instruction !== prev) begin
        errs++; $display("FAIL wait_cycle%0d: got req=%b stall=%b addr=%h instr=%h exp 1 1 44 %h", i, imem_req, fetch_stall, imem_addr, instruction, prev);
      end
      imem_ready = (i == 3);
      imem_rdata = (i == 3) ? 32'h0020_8063 : 32'hBAD0_BAD0;
      tick();
    end
    imem_ready    = 1'b0;
    stage_counter = 2'd0;
    chks++; if (instruction !== 32'h0020_8063 || fetch_stall !== 1'b0 || pc !== 32'h44) begin errs++; $display("FAIL wait_done: got instr=%h stall=%b pc=%h exp 00208063 0 44", instruction, fetch_stall, pc); end
    pc_update(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    IFU_reset_n = 1'b0;
    tick();
    IFU_reset_n = 1'b1;
    chks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instruction !== NOP || pc !== 32'h0) begin
      errs++; $display("FAIL reset_mid_wait: got req=%b addr=%h instr=%h pc=%h exp 1 0 %h 0", imem_req, imem_addr, instruction, pc, NOP);
    end
    fetch($urandom, 0);
  endtask

  task automatic test_misaligned;
    pc_update(2'b10, 32'h0, 32'h0000_0010);
    fetch($urandom, 0);
    pc_update(2'b01, 32'h0000_0002, 32'h0);
    chks++; if (misaligned_fetch !== 1'b1 || imem_req !== 1'b0 || instruction !== NOP || pc !== 32'h12 || fetch_stall !== 1'b0) begin
      errs++; $display("FAIL misaligned: got mis=%b req=%b instr=%h pc=%h stall=%b exp 1 0 %h 12 0", misaligned_fetch, imem_req, instruction, pc, fetch_stall, NOP);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ready = 1'b0;
    chks++; if (instruction !== NOP || imem_req !== 1'b0) begin errs++; $display("FAIL fault_ignores_ready: got instr=%h req=%b exp %h 0", instruction, imem_req, NOP); end
    pc_update(2'b00, 32'h0, 32'h0);
    chks++; if (misaligned_fetch !== 1'b1 || pc !== 32'h16 || imem_req !== 1'b0) begin errs++; $display("FAIL fault_stay: got mis=%b pc=%h req=%b exp 1 16 0", misaligned_fetch, pc, imem_req); end
    pc_update(2'b10, 32'h0, 32'h0000_0080);
    chks++; if (misaligned_fetch !== 1'b0 || imem_addr !== 32'h80 || imem_req !== 1'b1) begin errs++; $display("FAIL fault_recover: got mis=%b addr=%h req=%b exp 0 80 1", misaligned_fetch, imem_addr, imem_req); end
    fetch($urandom, 0);
  endtask

  task automatic test_timeout;
    int n;
    logic [31:0] d;
    imem_ready = 1'b0;
    pc_update(2'b00, 32'h0, 32'h0);
    n = 0;
    while (imem_req === 1'b1 && n < 120) begin
      n++;
      tick();
    end
`ifdef IFU_TIMEOUT_EN
    chks++; if (n !== 16) begin errs++; $display("FAIL timeout_cycles: got %0d exp 16", n); end
    chks++; if (fetch_timeout !== 1'b1 || instruction !== NOP || imem_req !== 1'b0) begin errs++; $display("FAIL timeout_flag: got to=%b instr=%h req=%b exp 1 %h 0", fetch_timeout, instruction, imem_req, NOP); end
    pc_update(2'b11, 32'h0, 32'h0);
    chks++; if (fetch_timeout !== 1'b1 || imem_req !== 1'b1) begin errs++; $display("FAIL timeout_sticky: got to=%b req=%b exp 1 1", fetch_timeout, imem_req); end
    d = $urandom;
    fetch(d, 15);
    chks++; if (fetch_timeout !== 1'b0 || instruction !== d) begin errs++; $display("FAIL handshake_at_expiry: got to=%b instr=%h exp 0 %h", fetch_timeout, instruction, d); end
`else
    chks++; if (n !== 120) begin errs++; $display("FAIL no_timeout_wait: got %0d exp 120", n); end
    chks++; if (fetch_timeout !== 1'b0 || imem_req !== 1'b1) begin errs++; $display("FAIL no_timeout_flag: got to=%b req=%b exp 0 1", fetch_timeout, imem_req); end
    d = $urandom;
    fetch(d, 0);
    chks++; if (instruction !== d) begin errs++; $display("FAIL no_timeout_late_data: got %h exp %h", instruction, d); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    logic [31:0] inc;
    logic [31:0] jt;
    logic [31:0] d;
    logic [1:0]  sel;
    pc_update(2'b10, 32'h0, 32'h0000_1000);
    fetch($urandom, 0);
    exp_pc = 32'h0000_1000;
    for (int it = 0; it < 40; it++) begin
      sel = 2'($urandom_range(0, 3));
      inc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      jt  = $urandom;
      case (sel)
        2'b00:   exp_next = exp_pc + 32'd4;
        2'b01:   exp_next = exp_pc + inc;
        2'b10:   exp_next = {jt[31:1], 1'b0};
        default: exp_next = exp_pc;
      endcase
      pc_update(sel, inc, jt);
      if (exp_next % 4 != 0) begin
        chks++; if (misaligned_fetch !== 1'b1 || pc !== exp_next || instruction !== NOP || imem_req !== 1'b0) begin
          errs++; $display("FAIL rnd_fault it=%0d: got mis=%b pc=%h instr=%h req=%b exp 1 %h %h 0", it, misaligned_fetch, pc, instruction, imem_req, exp_next, NOP);
        end
        exp_next = $urandom & 32'hFFFF_FFFC;
        pc_update(2'b10, 32'h0, exp_next | 32'h1);
      end
      exp_pc = exp_next;
      chks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc !== exp_pc || misaligned_fetch !== 1'b0) begin
        errs++; $display("FAIL rnd_req it=%0d: got req=%b addr=%h pc=%h mis=%b exp 1 %h %h 0", it, imem_req, imem_addr, pc, misaligned_fetch, exp_pc, exp_pc);
      end
      d = $urandom;
      fetch(d, $urandom_range(0, 3));
      chks++; if (instruction !== d || fetch_stall !== 1'b0 || pc !== exp_pc) begin
        errs++; $display("FAIL rnd_fetch it=%0d: got instr=%h stall=%b pc=%h exp %h 0 %h", it, instruction, fetch_stall, pc, d, exp_pc);
      end
    end
  endtask

  initial begin
    chks          = 0;
    errs          = 0;
    IFU_reset_n   = 1'b0;
    stage_counter = 2'd0;
    next_pc_sel   = 2'b00;
    pc_increment  = 32'h0;
    jump_target   = 32'h0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    test_reset();
    test_sequential();
    test_branch_jump();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", chks, errs);
    $finish;
  end

endmodule
